// File: rtl/uart_frame_bridge.sv
// ----------------------------------------------------------------------------
// uart_frame_bridge
//
// Avalon-MM master that streams one frame of H_PIX*V_PIX*BPP bytes into the
// UART TX data register, then reads RESULT_BYTES prediction bytes back from
// the UART RX data register. Every byte costs a status poll followed by the
// data transfer. Frame bytes come in through a ready/valid port into a
// one-entry staging register.
//
// Ports:
//   avm_clk, avm_rst_n     clock, asynchronous active-low reset
//   avm_address/read/write Avalon command (held until waitrequest drops)
//   avm_writedata          {24'b0, byte} during a TX data write, else 0
//   avm_readdata           status word or RX byte
//   avm_waitrequest        slave stall
//   i_start                begin a frame (looked at in IDLE only)
//   i_abort                abandon the frame at the next transfer boundary
//   i_tx_data/i_tx_valid   frame byte intake, o_tx_ready accepts it
//   o_rx_data/o_rx_valid   prediction byte, one-cycle strobe
//   o_rx_index             position of that byte within the results
//   o_busy                 frame in progress
//   o_done                 one-cycle strobe when frame and results complete
// ----------------------------------------------------------------------------
module uart_frame_bridge #(
    parameter int unsigned H_PIX        = 640,
    parameter int unsigned V_PIX        = 480,
    parameter int unsigned BPP          = 3,
    parameter int unsigned RESULT_BYTES = 120,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned RX_ADDR      = 0,
    parameter int unsigned TX_ADDR      = 4,
    parameter int unsigned STATUS_ADDR  = 8,
    parameter int unsigned TX_OK_BIT    = 6,
    parameter int unsigned RX_OK_BIT    = 7,
    localparam int unsigned FRAME_BYTES = H_PIX * V_PIX * BPP,
    localparam int unsigned MAX_CNT     = (FRAME_BYTES > RESULT_BYTES) ? FRAME_BYTES
                                                                       : RESULT_BYTES,
    localparam int unsigned CNT_W       = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1
) (
    input  logic              avm_clk,
    input  logic              avm_rst_n,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [7:0]        i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [7:0]        o_rx_data,
    output logic              o_rx_valid,
    output logic [CNT_W-1:0]  o_rx_index,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        StIdle,
        StTxPoll,
        StTxWrite,
        StRxPoll,
        StRxRead,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(RESULT_BYTES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] r_rx_cnt;
    logic             r_stage_full;
    logic [7:0]       r_stage_data;
    logic             r_abort_pending;
    logic             r_rx_valid;
    logic [7:0]       r_rx_data;
    logic [CNT_W-1:0] r_rx_index;

    logic w_bus_active;
    logic w_xfer_done;
    logic w_abort_req;
    logic w_abort_go;
    logic w_unused;

    // Only a few readdata bits are meaningful; fold the rest away.
    assign w_unused = ^avm_readdata;

    assign w_bus_active = (r_state == StTxPoll) || (r_state == StTxWrite) ||
                          (r_state == StRxPoll) || (r_state == StRxRead);
    assign w_xfer_done  = w_bus_active && !avm_waitrequest;

    // Abort waits for a transfer boundary so a stalled command is never dropped.
    assign w_abort_req  = (r_state != StIdle) && (i_abort || r_abort_pending);
    assign w_abort_go   = w_abort_req && (!w_bus_active || !avm_waitrequest);

    // Bus command is a pure function of state, so it stays put through stalls.
    always_comb begin
        w_state_next  = r_state;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = ADDR_W'(STATUS_ADDR);
        avm_writedata = 32'd0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StTxPoll;
                end
            end
            StTxPoll: begin
                avm_read = 1'b1;
                if (w_xfer_done && avm_readdata[TX_OK_BIT] && r_stage_full) begin
                    w_state_next = StTxWrite;
                end
            end
            StTxWrite: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_W'(TX_ADDR);
                avm_writedata = {24'd0, r_stage_data};
                if (w_xfer_done) begin
                    w_state_next = (r_tx_cnt == LAST_TX) ? StRxPoll : StTxPoll;
                end
            end
            StRxPoll: begin
                avm_read = 1'b1;
                if (w_xfer_done && avm_readdata[RX_OK_BIT]) begin
                    w_state_next = StRxRead;
                end
            end
            StRxRead: begin
                avm_read    = 1'b1;
                avm_address = ADDR_W'(RX_ADDR);
                if (w_xfer_done) begin
                    w_state_next = (r_rx_cnt == LAST_RX) ? StDone : StRxPoll;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        if (w_abort_go) begin
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_state         <= StIdle;
            r_tx_cnt        <= '0;
            r_rx_cnt        <= '0;
            r_stage_full    <= 1'b0;
            r_stage_data    <= 8'd0;
            r_abort_pending <= 1'b0;
            r_rx_valid      <= 1'b0;
            r_rx_data       <= 8'd0;
            r_rx_index      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rx_valid <= 1'b0;
            if (w_abort_go) begin
                r_tx_cnt        <= '0;
                r_rx_cnt        <= '0;
                r_stage_full    <= 1'b0;
                r_abort_pending <= 1'b0;
            end else begin
                if (w_abort_req) begin
                    r_abort_pending <= 1'b1;
                end
                case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_tx_cnt <= '0;
                            r_rx_cnt <= '0;
                        end
                    end
                    StTxPoll: begin
                        if (i_tx_valid && o_tx_ready) begin
                            r_stage_full <= 1'b1;
                            r_stage_data <= i_tx_data;
                        end
                    end
                    StTxWrite: begin
                        if (w_xfer_done) begin
                            r_stage_full <= 1'b0;
                            r_tx_cnt     <= r_tx_cnt + CNT_W'(1);
                        end
                    end
                    StRxRead: begin
                        if (w_xfer_done) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= avm_readdata[7:0];
                            r_rx_index <= r_rx_cnt;
                            r_rx_cnt   <= r_rx_cnt + CNT_W'(1);
                        end
                    end
                    StDone: begin
                        r_tx_cnt <= '0;
                        r_rx_cnt <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Intake closes while a byte is staged, outside TX_POLL, and once abort is seen.
    assign o_tx_ready = (r_state == StTxPoll) && !r_stage_full && !w_abort_req;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
    assign o_rx_index = r_rx_index;
    assign o_busy     = (r_state != StIdle);
    assign o_done     = (r_state == StDone) && !i_abort;

endmodule

// File: tb/tb_uart_frame_bridge.sv
module tb_uart_frame_bridge;
    localparam int unsigned H_PIX        = 4;
    localparam int unsigned V_PIX        = 2;
    localparam int unsigned BPP          = 3;
    localparam int unsigned RESULT_BYTES = 4;
    localparam int unsigned ADDR_W       = 5;
    localparam int unsigned RX_ADDR      = 0;
    localparam int unsigned TX_ADDR      = 4;
    localparam int unsigned STATUS_ADDR  = 8;
    localparam int unsigned FRAME_BYTES  = H_PIX * V_PIX * BPP;
    localparam int unsigned CNT_W        = $clog2(FRAME_BYTES);
    localparam int          TMO          = 5000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              i_start;
    logic              i_abort;
    logic [7:0]        i_tx_data;
    logic              i_tx_valid;
    logic              o_tx_ready;
    logic [7:0]        o_rx_data;
    logic              o_rx_valid;
    logic [CNT_W-1:0]  o_rx_index;
    logic              o_busy;
    logic              o_done;

    always #5 clk = ~clk;

    uart_frame_bridge #(
        .H_PIX(H_PIX), .V_PIX(V_PIX), .BPP(BPP), .RESULT_BYTES(RESULT_BYTES),
        .ADDR_W(ADDR_W), .RX_ADDR(RX_ADDR), .TX_ADDR(TX_ADDR), .STATUS_ADDR(STATUS_ADDR),
        .TX_OK_BIT(6), .RX_OK_BIT(7)
    ) dut (
        .avm_clk(clk), .avm_rst_n(rst_n),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .i_start(i_start), .i_abort(i_abort),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_rx_index(o_rx_index),
        .o_busy(o_busy), .o_done(o_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the producer handed over, what the slave returned.
    logic [7:0] frame_data [FRAME_BYTES];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    int acc_cnt, wr_cnt, rx_seen, done_cnt, rx_src_k;
    bit status_tx_ok, status_rx_ok, abort_seen;

    // Scenario knobs.
    bit seq_mode, rx_lit_mode, ok_random, txok_trig, trig_abort, trig_start_rx;
    bit start_pulse, abort_pulse;
    int wait_mode, txok_block, valid_pct;

    // Slave transfer tracking.
    bit                in_xfer, prev_stall;
    int                stall_left;
    logic              prev_rd, prev_wr;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_read", 32'(avm_read), 0);
        check("rst_write", 32'(avm_write), 0);
        check("rst_address", 32'(avm_address), 8);
        check("rst_writedata", avm_writedata, 0);
        check("rst_tx_ready", 32'(o_tx_ready), 0);
        check("rst_rx_valid", 32'(o_rx_valid), 0);
        check("rst_rx_data", 32'(o_rx_data), 0);
        check("rst_rx_index", 32'(o_rx_index), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
    endtask

    task automatic clear_slave();
        in_xfer    = 1'b0;
        prev_stall = 1'b0;
        stall_left = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_slave();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic new_frame(input bit seq, input bit rxlit);
        seq_mode     = seq;
        rx_lit_mode  = rxlit;
        acc_cnt      = 0;
        wr_cnt       = 0;
        rx_seen      = 0;
        done_cnt     = 0;
        rx_src_k     = 0;
        abort_seen   = 1'b0;
        status_tx_ok = 1'b0;
        status_rx_ok = 1'b0;
        tx_q.delete();
        rx_q.delete();
        for (int k = 0; k < int'(FRAME_BYTES); k++) begin
            frame_data[k] = seq ? 8'(k) : 8'($urandom);
        end
    endtask

    // One clock: check registered outputs, drive inputs, then record what the
    // upcoming edge will do.
    task automatic step();
        logic [31:0] rd;
        logic [7:0]  exp;
        @(negedge clk);
        if (o_rx_valid) begin
            check("rx_expected", 32'(rx_q.size() != 0), 1);
            if (rx_q.size() != 0) begin
                exp = rx_q.pop_front();
                check("rx_data", 32'(o_rx_data), 32'(exp));
            end
            check("rx_index", 32'(o_rx_index), rx_seen);
            if (rx_lit_mode) check("rx_data_lit", 32'(o_rx_data), 32'hA0 + rx_seen);
            rx_seen++;
        end
        if (o_done) begin
            check("done_rx_count", rx_seen, RESULT_BYTES);
            check("done_tx_count", wr_cnt, FRAME_BYTES);
            done_cnt++;
        end
        if (prev_stall) begin
            check("hold_read", 32'(avm_read), 32'(prev_rd));
            check("hold_write", 32'(avm_write), 32'(prev_wr));
            check("hold_address", 32'(avm_address), 32'(prev_addr));
            check("hold_writedata", avm_writedata, prev_wd);
        end
        if (!o_busy) check("idle_bus", {30'd0, avm_read, avm_write}, 0);

        i_start     = start_pulse;
        i_abort     = abort_pulse;
        start_pulse = 1'b0;
        abort_pulse = 1'b0;
        if (trig_start_rx && o_busy && wr_cnt == int'(FRAME_BYTES) && avm_read &&
            avm_address == ADDR_W'(STATUS_ADDR)) begin
            i_start       = 1'b1;
            trig_start_rx = 1'b0;
        end
        if (trig_abort && avm_write && wr_cnt == 6) begin
            i_abort    = 1'b1;
            trig_abort = 1'b0;
        end
        if (i_abort && o_busy) abort_seen = 1'b1;

        i_tx_data  = (acc_cnt < int'(FRAME_BYTES)) ? frame_data[acc_cnt] : 8'hEE;
        i_tx_valid = ($urandom_range(0, 9) < valid_pct);

        if (avm_read || avm_write) begin
            if (!in_xfer) begin
                in_xfer = 1'b1;
                case (wait_mode)
                    0:       stall_left = 0;
                    2:       stall_left = 3;
                    default: stall_left = int'($urandom_range(0, 2));
                endcase
            end
            avm_waitrequest = (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end else begin
            avm_waitrequest = 1'($urandom_range(0, 1));
        end
        rd = $urandom;
        if (avm_address == ADDR_W'(STATUS_ADDR)) begin
            rd[6] = (txok_block > 0) ? 1'b0 : (ok_random ? ($urandom_range(0, 3) != 0) : 1'b1);
            rd[7] = ok_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end else if (avm_address == ADDR_W'(RX_ADDR) && rx_lit_mode) begin
            rd[7:0] = 8'hA0 + 8'(rx_src_k);
        end
        avm_readdata = rd;

        #1;
        if (i_tx_valid && o_tx_ready) begin
            check("no_overaccept", 32'(acc_cnt < int'(FRAME_BYTES)), 1);
            check("single_stage", 32'(tx_q.size() == 0), 1);
            tx_q.push_back(i_tx_data);
            acc_cnt++;
        end else if (tx_q.size() != 0) begin
            check("ready_low_staged", 32'(o_tx_ready), 0);
        end

        if ((avm_read || avm_write) && !avm_waitrequest) begin
            in_xfer = 1'b0;
            if (avm_write) begin
                check("write_addr", 32'(avm_address), TX_ADDR);
                check("write_after_txok", 32'(status_tx_ok), 1);
                status_tx_ok = 1'b0;
                status_rx_ok = 1'b0;
                check("write_has_byte", 32'(tx_q.size() != 0), 1);
                if (tx_q.size() != 0) begin
                    exp = tx_q.pop_front();
                    check("writedata", avm_writedata, {24'd0, exp});
                end
                if (seq_mode) check("writedata_lit", avm_writedata, wr_cnt);
                wr_cnt++;
                if (txok_trig && wr_cnt == 5) begin
                    txok_block = 10;
                    txok_trig  = 1'b0;
                end
            end else if (avm_address == ADDR_W'(STATUS_ADDR)) begin
                status_tx_ok = avm_readdata[6];
                status_rx_ok = avm_readdata[7];
                if (txok_block > 0) txok_block--;
            end else begin
                check("read_addr", 32'(avm_address), RX_ADDR);
                check("read_after_rxok", 32'(status_rx_ok), 1);
                status_rx_ok = 1'b0;
                status_tx_ok = 1'b0;
                if (!abort_seen) rx_q.push_back(avm_readdata[7:0]);
                rx_src_k++;
            end
        end
        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_rd    = avm_read;
        prev_wr    = avm_write;
        prev_addr  = avm_address;
        prev_wd    = avm_writedata;
    endtask

    task automatic run_frame();
        int cyc = 0;
        start_pulse = 1'b1;
        step();
        @(posedge clk);
        #1;
        check("busy_after_start", 32'(o_busy), 1);
        while (done_cnt == 0 && cyc < TMO) begin
            step();
            cyc++;
        end
        check("frame_finished", 32'(cyc < TMO), 1);
        if (cyc >= TMO) apply_reset();
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(o_busy), 0);
        check("done_one_cycle", 32'(o_done), 0);
        repeat (5) step();
        check("tx_bytes", wr_cnt, FRAME_BYTES);
        check("rx_bytes", rx_seen, RESULT_BYTES);
        check("done_pulses", done_cnt, 1);
        check("tx_q_drained", tx_q.size(), 0);
        check("rx_q_drained", rx_q.size(), 0);
    endtask

    initial begin
        int cyc;
        rst_n           = 1'b0;
        avm_readdata    = 32'd0;
        avm_waitrequest = 1'b0;
        i_start         = 1'b0;
        i_abort         = 1'b0;
        i_tx_data       = 8'd0;
        i_tx_valid      = 1'b0;
        start_pulse     = 1'b0;
        abort_pulse     = 1'b0;
        txok_trig       = 1'b0;
        trig_abort      = 1'b0;
        trig_start_rx   = 1'b0;
        txok_block      = 0;
        ok_random       = 1'b0;
        wait_mode       = 0;
        valid_pct       = 10;
        clear_slave();
        new_frame(1'b1, 1'b1);
        #2;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Sequential bytes, zero-wait slave, flags always set.
        new_frame(1'b1, 1'b1);
        wait_mode = 0; ok_random = 1'b0; valid_pct = 10;
        run_frame();

        // Three-cycle stall on every transfer.
        new_frame(1'b0, 1'b0);
        wait_mode = 2;
        run_frame();

        // TX_OK held low for ten polls once five bytes are out.
        new_frame(1'b0, 1'b0);
        wait_mode = 1; valid_pct = 7; txok_trig = 1'b1;
        run_frame();
        check("txok_trigger_fired", 32'(txok_trig), 0);
        check("txok_polls_used", txok_block, 0);

        // Abort during the stalled 7th write.
        new_frame(1'b1, 1'b1);
        wait_mode = 2; valid_pct = 10; trig_abort = 1'b1;
        start_pulse = 1'b1;
        step();
        cyc = 0;
        while (!(abort_seen && !o_busy) && cyc < TMO) begin
            step();
            cyc++;
        end
        check("abort_reached_idle", 32'(cyc < TMO), 1);
        check("abort_writes", wr_cnt, 7);
        check("abort_rx", rx_seen, 0);
        repeat (20) step();
        check("abort_no_more_writes", wr_cnt, 7);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", 32'(o_busy), 0);

        // Restart from byte 0; start and abort together in IDLE.
        new_frame(1'b1, 1'b1);
        wait_mode = 0; abort_pulse = 1'b1;
        run_frame();

        // Start pulsed during RX polling is ignored.
        new_frame(1'b0, 1'b1);
        wait_mode = 1; trig_start_rx = 1'b1;
        run_frame();
        check("start_rx_trigger_fired", 32'(trig_start_rx), 0);

        // Asynchronous reset in the middle of an RX data read.
        new_frame(1'b0, 1'b1);
        wait_mode = 2;
        start_pulse = 1'b1;
        step();
        cyc = 0;
        while (!(avm_read && avm_address == ADDR_W'(RX_ADDR) && rx_seen >= 1) && cyc < TMO) begin
            step();
            cyc++;
        end
        check("reached_rx_read", 32'(cyc < TMO), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        clear_slave();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            new_frame(1'b0, 1'b0);
            wait_mode = 1; ok_random = 1'b1; valid_pct = 6;
            run_frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
